// File: rtl/ring_rr_arbiter_if.sv
`default_nettype none
// ============================================================================
// Module   : ring_rr_arbiter_if
// Brief    : Request/grant bundle between requesting engines and the arbiter.
// Revision : 1.0 - initial release
// ============================================================================
interface ring_rr_arbiter_if #(
  parameter int N   = 4,
  parameter int IDW = $clog2(N)
);
  logic           en;
  logic [N-1:0]   req;
  logic [N-1:0]   gnt;
  logic [IDW-1:0] gnt_id;
  logic           busy;
  logic           expired;
  logic [N-1:0]   ptr;

  modport master (output en, req, input gnt, gnt_id, busy, expired, ptr);
  modport slave  (input en, req, output gnt, gnt_id, busy, expired, ptr);
endinterface
`default_nettype wire

// File: rtl/ring_rr_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : ring_rr_arbiter
// Brief    : One-hot ring-pointer round-robin arbiter with per-grant quantum.
// Revision : 1.0 - initial release
// ============================================================================
module ring_rr_arbiter #(
  parameter int N       = 4,
  parameter int QUANTUM = 4,
  parameter int IDW     = $clog2(N)
) (
  input  logic             clk,
  input  logic             reset_n,
  ring_rr_arbiter_if.slave bus
);
  localparam int              CW         = (QUANTUM > 1) ? $clog2(QUANTUM) : 1;
  localparam logic [CW-1:0]   c_cnt_last = CW'(QUANTUM - 1);
  localparam logic [IDW:0]    c_n        = (IDW + 1)'(N);

  typedef enum logic [0:0] {
    S_IDLE  = 1'b0,
    S_GRANT = 1'b1
  } state_t;

  state_t         r_state;
  logic [N-1:0]   r_gnt;
  logic [N-1:0]   r_ptr;
  logic [IDW-1:0] r_gnt_id;
  logic [CW-1:0]  r_cnt;
  logic           r_expired;

  logic [IDW-1:0] w_ptr_id;
  logic [IDW-1:0] w_win_id;
  logic [IDW:0]   w_idx;
  logic           w_found;
  logic [N-1:0]   w_win_oh;
  logic [N-1:0]   w_ptr_next;
  logic           w_owner_req;

  // Circular search starting at the pointer position, wrapping N-1 -> 0.
  always_comb begin
    w_ptr_id = '0;
    for (int i = 0; i < N; i++) begin
      if (r_ptr[i]) w_ptr_id = w_ptr_id | IDW'(i);
    end
    w_found  = 1'b0;
    w_win_id = '0;
    w_idx    = '0;
    for (int off = 0; off < N; off++) begin
      w_idx = {1'b0, w_ptr_id} + (IDW + 1)'(off);
      if (w_idx >= c_n) w_idx = w_idx - c_n;
      if (!w_found && bus.req[w_idx[IDW-1:0]]) begin
        w_found  = 1'b1;
        w_win_id = w_idx[IDW-1:0];
      end
    end
    w_win_oh           = '0;
    w_win_oh[w_win_id] = w_found;
  end

  assign w_owner_req = |(bus.req & r_gnt);
  assign w_ptr_next  = {r_gnt[N-2:0], r_gnt[N-1]};

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state   <= S_IDLE;
      r_gnt     <= '0;
      r_gnt_id  <= '0;
      r_ptr     <= N'(1);
      r_cnt     <= '0;
      r_expired <= 1'b0;
    end else begin
      r_expired <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (bus.en && w_found) begin
            r_state  <= S_GRANT;
            r_gnt    <= w_win_oh;
            r_gnt_id <= w_win_id;
            r_cnt    <= '0;
          end
        end
        S_GRANT: begin
          // Owner's own release takes precedence over quantum expiry.
          if (!w_owner_req || (r_cnt == c_cnt_last)) begin
            r_state   <= S_IDLE;
            r_gnt     <= '0;
            r_gnt_id  <= '0;
            r_ptr     <= w_ptr_next;
            r_expired <= w_owner_req;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign bus.gnt     = r_gnt;
  assign bus.gnt_id  = r_gnt_id;
  assign bus.busy    = |r_gnt;
  assign bus.expired = r_expired;
  assign bus.ptr     = r_ptr;
endmodule
`default_nettype wire

// File: tb/tb_ring_rr_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_ring_rr_arbiter
// Brief    : Self-checking bench for ring_rr_arbiter (N=4, QUANTUM=4).
// Revision : 1.0 - initial release
// ============================================================================
module tb_ring_rr_arbiter;
  localparam int N       = 4;
  localparam int QUANTUM = 4;
  localparam int IDW     = 2;

  logic clk;
  logic reset_n;
  int   checks;
  int   errors;

  ring_rr_arbiter_if #(.N(N), .IDW(IDW)) bus ();

  ring_rr_arbiter #(.N(N), .QUANTUM(QUANTUM), .IDW(IDW)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: owner index (-1 = none), cycles held, pointer index.
  int m_owner;
  int m_held;
  int m_ptr;
  bit m_exp;

  task automatic model_reset();
    m_owner = -1;
    m_held  = 0;
    m_ptr   = 0;
    m_exp   = 1'b0;
  endtask

  task automatic model_step(input bit en, input bit [N-1:0] req);
    m_exp = 1'b0;
    if (m_owner < 0) begin
      if (en && req != 0) begin
        for (int k = 0; k < N; k++) begin
          if (m_owner < 0 && req[(m_ptr + k) % N]) m_owner = (m_ptr + k) % N;
        end
        m_held = 1;
      end
    end else if (!req[m_owner] || m_held == QUANTUM) begin
      m_exp   = req[m_owner];
      m_ptr   = (m_owner + 1) % N;
      m_owner = -1;
    end else begin
      m_held++;
    end
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [IDW-1:0] id_of(input logic [N-1:0] oh);
    logic [IDW-1:0] r;
    r = '0;
    for (int i = 0; i < N; i++) if (oh[i]) r = IDW'(i);
    return r;
  endfunction

  task automatic check_outputs(input string tag, input logic [N-1:0] g, input logic [N-1:0] p,
                               input logic e);
    check({tag, ".gnt"},     32'(bus.gnt),     32'(g));
    check({tag, ".gnt_id"},  32'(bus.gnt_id),  32'(id_of(g)));
    check({tag, ".busy"},    32'(bus.busy),    32'(|g));
    check({tag, ".expired"}, 32'(bus.expired), 32'(e));
    check({tag, ".ptr"},     32'(bus.ptr),     32'(p));
  endtask

  task automatic check_model(input string tag);
    logic [N-1:0] g;
    g = (m_owner < 0) ? '0 : N'(1) << m_owner;
    check_outputs(tag, g, N'(1) << m_ptr, m_exp);
  endtask

  // Drive inputs away from the edge, clock once, sample 1 time unit after.
  task automatic tick(input bit en, input bit [N-1:0] req);
    bus.en  = en;
    bus.req = req;
    @(posedge clk);
    #1;
    model_step(en, req);
  endtask

  typedef struct {
    bit           en;
    bit [N-1:0]   req;
    logic [N-1:0] gnt;
    logic [N-1:0] ptr;
    logic         exp;
  } vec_t;

  vec_t vecs[$];

  task automatic add(input bit en, input bit [N-1:0] req, input logic [N-1:0] gnt,
                     input logic [N-1:0] ptr, input logic exp);
    vec_t v;
    v.en = en; v.req = req; v.gnt = gnt; v.ptr = ptr; v.exp = exp;
    vecs.push_back(v);
  endtask

  initial begin
    bit          en_r;
    bit [N-1:0]  req_r;
    checks = 0;
    errors = 0;
    model_reset();

    // Reset held with all requests high.
    reset_n = 1'b0;
    bus.en  = 1'b1;
    bus.req = 4'b1111;
    repeat (3) @(posedge clk);
    #1;
    check_outputs("reset_hold", 4'b0000, 4'b0001, 1'b0);
    @(negedge clk);
    reset_n = 1'b1;
    bus.req = 4'b0000;

    // Rotation: each owner 4 cycles then a 1-cycle bubble with expired.
    for (int r = 0; r < 5; r++) begin
      for (int c = 0; c < 4; c++) add(1, 4'b1111, 4'(1 << (r % 4)), 4'(1 << (r % 4)), 0);
      if (r < 4) add(1, 4'b1111, 4'b0000, 4'(1 << ((r + 1) % 4)), 1);
    end
    add(1, 4'b0000, 4'b0000, 4'b0010, 0);
    // Early release of requester 2.
    add(1, 4'b0100, 4'b0100, 4'b0010, 0);
    add(1, 4'b0100, 4'b0100, 4'b0010, 0);
    add(1, 4'b0000, 4'b0000, 4'b1000, 0);
    // Wrap search from ptr=1000.
    add(1, 4'b0011, 4'b0001, 4'b1000, 0);
    add(1, 4'b0000, 4'b0000, 4'b0010, 0);
    // Enable gating, idle and mid-grant.
    add(0, 4'b0010, 4'b0000, 4'b0010, 0);
    add(0, 4'b0010, 4'b0000, 4'b0010, 0);
    add(1, 4'b0010, 4'b0010, 4'b0010, 0);
    add(0, 4'b0010, 4'b0010, 4'b0010, 0);
    add(0, 4'b0010, 4'b0010, 4'b0010, 0);
    add(0, 4'b0010, 4'b0010, 4'b0010, 0);
    add(0, 4'b0010, 4'b0000, 4'b0100, 1);
    add(0, 4'b0010, 4'b0000, 4'b0100, 0);
    add(1, 4'b0010, 4'b0010, 4'b0100, 0);
    // Owner drops req on the edge its quantum would expire.
    add(1, 4'b0010, 4'b0010, 4'b0100, 0);
    add(1, 4'b0010, 4'b0010, 4'b0100, 0);
    add(1, 4'b0010, 4'b0010, 4'b0100, 0);
    add(1, 4'b0000, 4'b0000, 4'b0100, 0);
    // Late requester 2 waits through the bubble.
    add(1, 4'b0001, 4'b0001, 4'b0100, 0);
    add(1, 4'b0101, 4'b0001, 4'b0100, 0);
    add(1, 4'b0100, 4'b0000, 4'b0010, 0);
    add(1, 4'b0100, 4'b0100, 4'b0010, 0);
    add(1, 4'b0000, 4'b0000, 4'b1000, 0);

    foreach (vecs[i]) begin
      tick(vecs[i].en, vecs[i].req);
      check_outputs($sformatf("vec%0d", i), vecs[i].gnt, vecs[i].ptr, vecs[i].exp);
    end

    // Randomized traffic against the reference model.
    req_r = '0;
    for (int i = 0; i < 400; i++) begin
      en_r = ($urandom_range(0, 4) != 0);
      for (int b = 0; b < N; b++) begin
        if ($urandom_range(0, 3) == 0) req_r[b] = ~req_r[b];
      end
      tick(en_r, req_r);
      check_model($sformatf("rnd%0d", i));
    end

    // Asynchronous reset mid-grant clears outputs before the next edge.
    tick(1, 4'b0000);
    tick(1, 4'b0000);
    tick(1, 4'b1000);
    check_model("pre_reset");
    check("pre_reset.busy_set", 32'(bus.busy), 32'd1);
    #2;
    reset_n = 1'b0;
    #1;
    model_reset();
    check_outputs("async_reset", 4'b0000, 4'b0001, 1'b0);
    @(negedge clk);
    reset_n = 1'b1;
    tick(1, 4'b1000);
    check_outputs("post_reset", 4'b1000, 4'b0001, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
`default_nettype wire
